// File: rtl/cfg_mailbox_pkg.sv
// Shared types and register map for the N64 config command mailbox.
// Used by cfg_cmd_mailbox and cfg_mailbox_watchdog.
package cfg_mailbox_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENDING = 2'd1,
        S_EXEC    = 2'd2
    } e_mailbox_state;

    localparam logic [1:0] REG_STATUS   = 2'd0;
    localparam logic [1:0] REG_ARG0     = 2'd1;
    localparam logic [1:0] REG_ARG1     = 2'd2;
    localparam logic [1:0] REG_RESPONSE = 2'd3;

    localparam int unsigned STAT_BOOT_BIT    = 31;
    localparam int unsigned STAT_BUSY_BIT    = 30;
    localparam int unsigned STAT_OVERRUN_BIT = 29;
    localparam int unsigned STAT_TIMEOUT_BIT = 28;

    localparam logic [31:0] TIMEOUT_RESPONSE = 32'hFFFF_FFFF;

    function automatic logic [31:0] pack_status(
        input logic       boot,
        input logic       busy,
        input logic       overrun,
        input logic       timeout,
        input logic [7:0] cmd
    );
        logic [31:0] s;
        s                   = '0;
        s[STAT_BOOT_BIT]    = boot;
        s[STAT_BUSY_BIT]    = busy;
        s[STAT_OVERRUN_BIT] = overrun;
        s[STAT_TIMEOUT_BIT] = timeout;
        s[7:0]              = cmd;
        return s;
    endfunction

endpackage

// File: rtl/cfg_mailbox_watchdog.sv
// Command watchdog: counts cycles while start is high, flags expiry after
// TIMEOUT_CYCLES cycles. Only instantiated when CMD_WATCHDOG_EN is defined.
module cfg_mailbox_watchdog
    import cfg_mailbox_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic clear,
    output logic expired
);

    logic [23:0] count_q, count_d;

    // Expires during the TIMEOUT_CYCLES-th counted cycle so the owner leaves
    // its busy state on exactly that edge.
    assign expired = start && !clear &&
                     (({1'b0, count_q} + 25'd1) >= {1'b0, TIMEOUT_CYCLES});

    always_comb begin
        count_d = count_q;
        if (clear || !start) begin
            count_d = '0;
        end else if (!expired) begin
            count_d = count_q + 24'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cfg_cmd_mailbox.sv
// Command mailbox between the N64 config register stage and the controller CPU.
// Optional command watchdog enabled by defining CMD_WATCHDOG_EN.
module cfg_cmd_mailbox
    import cfg_mailbox_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        n64_cmd_request,
    input  logic [7:0]  n64_command,
    input  logic [31:0] n64_arg0,
    input  logic [31:0] n64_arg1,
    output logic [31:0] n64_response,
    output logic        cpu_busy,
    output logic        cpu_bootstrapped,
    input  logic        cpu_req,
    input  logic        cpu_write,
    input  logic [1:0]  cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        irq
);

    e_mailbox_state state_q, state_d;

    logic        busy_q, busy_d;
    logic        boot_q, boot_d;
    logic        irq_q, irq_d;
    logic        overrun_q, overrun_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [31:0] arg0_q, arg0_d;
    logic [31:0] arg1_q, arg1_d;
    logic [31:0] resp_q, resp_d;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic        acc_write_q, acc_write_d;
    logic [1:0]  acc_addr_q, acc_addr_d;
    logic [31:0] acc_wdata_q, acc_wdata_d;

    logic        accept;
    logic [31:0] read_data;
    logic        wr_resp;
    logic        wr_status;
    logic        rd_status;
    logic        wd_expired;

    // An access is sampled on the accept edge and takes effect on the edge
    // that ends the ack cycle, so side effects trail the ack by one cycle.
    assign accept    = cpu_req && !ack_q;
    assign wr_resp   = ack_q && acc_write_q && (acc_addr_q == REG_RESPONSE);
    assign wr_status = ack_q && acc_write_q && (acc_addr_q == REG_STATUS);
    assign rd_status = ack_q && !acc_write_q && (acc_addr_q == REG_STATUS);

`ifdef CMD_WATCHDOG_EN
    logic wd_start;
    logic wd_clear;

    assign wd_start = (state_q != S_IDLE);
    assign wd_clear = (state_q == S_IDLE) && n64_cmd_request;

    cfg_mailbox_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (wd_start),
        .clear   (wd_clear),
        .expired (wd_expired)
    );
`else
    logic unused_timeout_cycles;

    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign wd_expired            = 1'b0;
`endif

    always_comb begin
        read_data = '0;
        case (cpu_addr)
            REG_STATUS:   read_data = pack_status(boot_q, busy_q, overrun_q, timeout_q, cmd_q);
            REG_ARG0:     read_data = arg0_q;
            REG_ARG1:     read_data = arg1_q;
            REG_RESPONSE: read_data = resp_q;
            default:      read_data = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        boot_d      = boot_q;
        irq_d       = irq_q;
        overrun_d   = overrun_q;
        timeout_d   = timeout_q;
        cmd_d       = cmd_q;
        arg0_d      = arg0_q;
        arg1_d      = arg1_q;
        resp_d      = resp_q;
        acc_write_d = acc_write_q;
        acc_addr_d  = acc_addr_q;
        acc_wdata_d = acc_wdata_q;

        ack_d   = accept;
        rdata_d = (accept && !cpu_write) ? read_data : 32'd0;
        if (accept) begin
            acc_write_d = cpu_write;
            acc_addr_d  = cpu_addr;
            acc_wdata_d = cpu_wdata;
        end

        if (wr_status) begin
            if (acc_wdata_q[STAT_BOOT_BIT]) boot_d = 1'b1;
            if (acc_wdata_q[STAT_OVERRUN_BIT]) overrun_d = 1'b0;
            if (acc_wdata_q[STAT_TIMEOUT_BIT]) timeout_d = 1'b0;
        end

        // A request while a command is outstanding is dropped but remembered.
        if (n64_cmd_request && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (n64_cmd_request) begin
                    cmd_d   = n64_command;
                    arg0_d  = n64_arg0;
                    arg1_d  = n64_arg1;
                    busy_d  = 1'b1;
                    irq_d   = 1'b1;
                    state_d = S_PENDING;
                end
            end
            S_PENDING, S_EXEC: begin
                if (wr_resp) begin
                    resp_d  = acc_wdata_q;
                    busy_d  = 1'b0;
                    irq_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (wd_expired) begin
                    resp_d    = TIMEOUT_RESPONSE;
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    irq_d     = 1'b0;
                    state_d   = S_IDLE;
                end else if (rd_status && (state_q == S_PENDING)) begin
                    irq_d   = 1'b0;
                    state_d = S_EXEC;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                irq_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            boot_q      <= 1'b0;
            irq_q       <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
            cmd_q       <= '0;
            arg0_q      <= '0;
            arg1_q      <= '0;
            resp_q      <= '0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
            acc_write_q <= 1'b0;
            acc_addr_q  <= '0;
            acc_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            boot_q      <= boot_d;
            irq_q       <= irq_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
            cmd_q       <= cmd_d;
            arg0_q      <= arg0_d;
            arg1_q      <= arg1_d;
            resp_q      <= resp_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            acc_write_q <= acc_write_d;
            acc_addr_q  <= acc_addr_d;
            acc_wdata_q <= acc_wdata_d;
        end
    end

    assign n64_response     = resp_q;
    assign cpu_busy         = busy_q;
    assign cpu_bootstrapped = boot_q;
    assign irq              = irq_q;
    assign cpu_ack          = ack_q;
    assign cpu_rdata        = rdata_q;

endmodule

// File: tb/tb_cfg_cmd_mailbox.sv
// Directed self-checking bench for cfg_cmd_mailbox; the watchdog scenario
// runs when CMD_WATCHDOG_EN is defined, otherwise the no-timeout behaviour.
module tb_cfg_cmd_mailbox;

    logic        clk;
    logic        reset_n;
    logic        n64_cmd_request;
    logic [7:0]  n64_command;
    logic [31:0] n64_arg0;
    logic [31:0] n64_arg1;
    logic [31:0] n64_response;
    logic        cpu_busy;
    logic        cpu_bootstrapped;
    logic        cpu_req;
    logic        cpu_write;
    logic [1:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic        irq;

    int checks;
    int fails;

    cfg_cmd_mailbox #(
        .TIMEOUT_CYCLES (24'd16)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .n64_cmd_request  (n64_cmd_request),
        .n64_command      (n64_command),
        .n64_arg0         (n64_arg0),
        .n64_arg1         (n64_arg1),
        .n64_response     (n64_response),
        .cpu_busy         (cpu_busy),
        .cpu_bootstrapped (cpu_bootstrapped),
        .cpu_req          (cpu_req),
        .cpu_write        (cpu_write),
        .cpu_addr         (cpu_addr),
        .cpu_wdata        (cpu_wdata),
        .cpu_rdata        (cpu_rdata),
        .cpu_ack          (cpu_ack),
        .irq              (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic n64_req(input logic [7:0] cmd, input logic [31:0] a0, input logic [31:0] a1);
        @(negedge clk);
        n64_cmd_request = 1'b1;
        n64_command     = cmd;
        n64_arg0        = a0;
        n64_arg1        = a1;
        @(negedge clk);
        n64_cmd_request = 1'b0;
    endtask

    // Returns at the negedge after the access has taken effect.
    task automatic cpu_xfer(input logic wr, input logic [1:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd);
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_write = wr;
        cpu_addr  = addr;
        cpu_wdata = wd;
        @(negedge clk);
        check_eq("ack_high", {31'd0, cpu_ack}, 32'd1);
        rd      = cpu_rdata;
        cpu_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        checks          = 0;
        fails           = 0;
        reset_n         = 1'b0;
        n64_cmd_request = 1'b0;
        n64_command     = '0;
        n64_arg0        = '0;
        n64_arg1        = '0;
        cpu_req         = 1'b0;
        cpu_write       = 1'b0;
        cpu_addr        = '0;
        cpu_wdata       = '0;

        #12;
        check_eq("rst_busy", {31'd0, cpu_busy}, 32'd0);
        check_eq("rst_boot", {31'd0, cpu_bootstrapped}, 32'd0);
        check_eq("rst_irq", {31'd0, irq}, 32'd0);
        check_eq("rst_ack", {31'd0, cpu_ack}, 32'd0);
        check_eq("rst_resp", n64_response, 32'd0);
        check_eq("rst_rdata", cpu_rdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic command round trip
        n64_req(8'h5A, 32'h1234_5678, 32'h0BAD_F00D);
        check_eq("req_busy", {31'd0, cpu_busy}, 32'd1);
        check_eq("req_irq", {31'd0, irq}, 32'd1);
        cpu_xfer(1'b0, 2'd0, 32'd0, rd);
        check_eq("status_first", rd, 32'h4000_005A);
        check_eq("irq_cleared", {31'd0, irq}, 32'd0);
        check_eq("rdata_idle", cpu_rdata, 32'd0);
        cpu_xfer(1'b0, 2'd1, 32'd0, rd);
        check_eq("arg0", rd, 32'h1234_5678);
        cpu_xfer(1'b0, 2'd2, 32'd0, rd);
        check_eq("arg1", rd, 32'h0BAD_F00D);

        // Overrun while executing
        n64_req(8'h11, 32'h1111_1111, 32'h2222_2222);
        cpu_xfer(1'b0, 2'd0, 32'd0, rd);
        check_eq("status_overrun", rd, 32'h6000_005A);
        cpu_xfer(1'b1, 2'd0, 32'h2000_0000, rd);
        cpu_xfer(1'b0, 2'd0, 32'd0, rd);
        check_eq("overrun_cleared", rd, 32'h4000_005A);
        cpu_xfer(1'b1, 2'd1, 32'hDEAD_BEEF, rd);
        cpu_xfer(1'b0, 2'd1, 32'd0, rd);
        check_eq("arg0_readonly", rd, 32'h1234_5678);

        // Response write: busy still high during the ack cycle, low after
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_write = 1'b1;
        cpu_addr  = 2'd3;
        cpu_wdata = 32'hCAFE_0001;
        @(negedge clk);
        cpu_req = 1'b0;
        check_eq("resp_ack", {31'd0, cpu_ack}, 32'd1);
        check_eq("busy_during_ack", {31'd0, cpu_busy}, 32'd1);
        @(negedge clk);
        check_eq("busy_after_resp", {31'd0, cpu_busy}, 32'd0);
        check_eq("n64_response", n64_response, 32'hCAFE_0001);
        check_eq("ack_single", {31'd0, cpu_ack}, 32'd0);
        cpu_xfer(1'b0, 2'd3, 32'd0, rd);
        check_eq("resp_readback", rd, 32'hCAFE_0001);

        // Bootstrapped flag is sticky
        cpu_xfer(1'b1, 2'd0, 32'h8000_0000, rd);
        check_eq("boot_set", {31'd0, cpu_bootstrapped}, 32'd1);
        cpu_xfer(1'b1, 2'd0, 32'h0000_0000, rd);
        check_eq("boot_sticky", {31'd0, cpu_bootstrapped}, 32'd1);
        cpu_xfer(1'b0, 2'd0, 32'd0, rd);
        check_eq("status_idle_boot", rd, 32'h8000_005A);

        // Request coincident with the response write is dropped
        n64_req(8'h33, 32'h0000_0001, 32'h0000_0002);
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_write = 1'b1;
        cpu_addr  = 2'd3;
        cpu_wdata = 32'h0000_0077;
        @(negedge clk);
        cpu_req         = 1'b0;
        n64_cmd_request = 1'b1;
        n64_command     = 8'h44;
        n64_arg0        = 32'h4444_4444;
        @(negedge clk);
        n64_cmd_request = 1'b0;
        check_eq("coinc_busy", {31'd0, cpu_busy}, 32'd0);
        check_eq("coinc_resp", n64_response, 32'h0000_0077);
        cpu_xfer(1'b0, 2'd0, 32'd0, rd);
        check_eq("coinc_status", rd, 32'hA000_0033);
        cpu_xfer(1'b0, 2'd1, 32'd0, rd);
        check_eq("coinc_arg0", rd, 32'h0000_0001);
        cpu_xfer(1'b1, 2'd0, 32'h2000_0000, rd);

`ifdef CMD_WATCHDOG_EN
        n64_req(8'h66, 32'h6, 32'h7);
        repeat (15) @(negedge clk);
        check_eq("wd_busy_before", {31'd0, cpu_busy}, 32'd1);
        @(negedge clk);
        check_eq("wd_busy", {31'd0, cpu_busy}, 32'd0);
        check_eq("wd_resp", n64_response, 32'hFFFF_FFFF);
        check_eq("wd_irq", {31'd0, irq}, 32'd0);
        cpu_xfer(1'b0, 2'd0, 32'd0, rd);
        check_eq("wd_status", rd, 32'h9000_0066);
        cpu_xfer(1'b1, 2'd0, 32'h1000_0000, rd);
        cpu_xfer(1'b0, 2'd0, 32'd0, rd);
        check_eq("wd_cleared", rd, 32'h8000_0066);
`else
        n64_req(8'h66, 32'h6, 32'h7);
        repeat (40) @(negedge clk);
        check_eq("nowd_busy", {31'd0, cpu_busy}, 32'd1);
        cpu_xfer(1'b0, 2'd0, 32'd0, rd);
        check_eq("nowd_status", rd, 32'hC000_0066);
        cpu_xfer(1'b1, 2'd3, 32'h0000_0001, rd);
        check_eq("nowd_done", {31'd0, cpu_busy}, 32'd0);
`endif

        // Asynchronous reset in the middle of an executing command
        n64_req(8'h77, 32'h7777_0000, 32'h0);
        cpu_xfer(1'b0, 2'd0, 32'd0, rd);
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_write = 1'b0;
        cpu_addr  = 2'd0;
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        check_eq("arst_busy", {31'd0, cpu_busy}, 32'd0);
        check_eq("arst_boot", {31'd0, cpu_bootstrapped}, 32'd0);
        check_eq("arst_irq", {31'd0, irq}, 32'd0);
        check_eq("arst_ack", {31'd0, cpu_ack}, 32'd0);
        check_eq("arst_rdata", cpu_rdata, 32'd0);
        check_eq("arst_resp", n64_response, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cpu_xfer(1'b0, 2'd0, 32'd0, rd);
        check_eq("post_rst_status", rd, 32'h0000_0000);
        n64_req(8'h01, 32'hA5A5_A5A5, 32'h0);
        check_eq("post_rst_busy", {31'd0, cpu_busy}, 32'd1);
        cpu_xfer(1'b0, 2'd0, 32'd0, rd);
        check_eq("post_rst_status2", rd, 32'h4000_0001);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/cfg_cmd_mailbox.md
CFG_CMD_MAILBOX -- requirements
Module: cfg_cmd_mailbox

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 24'd1_000_000, meaning the command watchdog limit in clk cycles.
REQ-002 SHALL have port clk, input, 1, the single clock; reset is asynchronous and active-low.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port n64_cmd_request, input, 1, one-cycle pulse from the N64 config register stage.
REQ-005 SHALL have port n64_command, input, 8, command code (valid with request).
REQ-006 SHALL have ports n64_arg0 and n64_arg1, input, 32 each, command arguments.
REQ-007 SHALL have port n64_response, output, 32, response word back to the N64 config stage.
REQ-008 SHALL have ports cpu_busy and cpu_bootstrapped, output, 1 each, status to the N64 config stage.
REQ-009 SHALL have ports cpu_req, input, 1; cpu_write, input, 1; cpu_addr, input, 2; cpu_wdata, input, 32; controller CPU register access.
REQ-010 SHALL have ports cpu_rdata, output, 32, and cpu_ack, output, 1, read data and access acknowledge.
REQ-011 SHALL have port irq, output, 1, level interrupt to the controller CPU.

Function
REQ-012 SHALL implement states S_IDLE, S_PENDING, S_EXEC.
REQ-013 SHALL, in S_IDLE on n64_cmd_request, latch command/arg0/arg1, set cpu_busy and irq, enter S_PENDING the next cycle.
REQ-014 SHALL, in S_PENDING on CPU read of addr 0 (STATUS), clear irq and enter S_EXEC.
REQ-015 SHALL, in S_PENDING or S_EXEC on CPU write of addr 3 (RESPONSE), load n64_response from cpu_wdata, clear cpu_busy and irq, return to S_IDLE; the N64 sees busy low the cycle after the write is acked.
REQ-016 SHALL ignore n64_cmd_request outside S_IDLE (latched values unchanged) and set sticky overrun flag.
REQ-017 SHALL, on request coincident with the RESPONSE write, complete the response and ignore the request (overrun set).
REQ-018 SHALL assert cpu_ack exactly one cycle after cpu_req, one access per two cycles, cpu_rdata valid while cpu_ack is high, else 0.
REQ-019 SHALL map STATUS read as {bootstrapped, busy, overrun, timeout, 20'd0, command}; addr 1 = arg0, addr 2 = arg1 (read-only, writes ignored); addr 3 reads current response.
REQ-020 SHALL, on STATUS write, set cpu_bootstrapped if wdata[31]=1 (never cleared except by reset), clear overrun if wdata[29]=1, clear timeout if wdata[28]=1.

Reset
REQ-021 SHALL on reset_n low immediately force S_IDLE, cpu_busy=0, cpu_bootstrapped=0, irq=0, cpu_ack=0, n64_response=0, command/args=0, overrun=0, timeout=0, watchdog=0.
REQ-022 SHALL abandon any in-flight command on reset with no response written.

Configuration
REQ-023 SHALL, with CMD_WATCHDOG_EN defined, count cycles in S_PENDING/S_EXEC; at TIMEOUT_CYCLES set n64_response=32'hFFFF_FFFF, set timeout flag, clear busy/irq, enter S_IDLE; counter cleared on entering S_PENDING.
REQ-024 SHALL, without CMD_WATCHDOG_EN, contain no counter, keep STATUS bit 28 at 0, and wait indefinitely.

Structure
REQ-025 SHALL place e_mailbox_state, register address constants (REG_STATUS=0, REG_ARG0=1, REG_ARG1=2, REG_RESPONSE=3) and status bit indices in a shared package cfg_mailbox_pkg.
REQ-026 SHALL implement the watchdog as sub-module cfg_mailbox_watchdog (start, clear, expired).

Verification
REQ-027 SHALL test: request cmd 8'h5A, arg0 32'h1234_5678 -> busy=1, irq=1; STATUS read returns 0x4000_005A -> irq=0; RESPONSE write 32'hCAFE_0001 -> busy=0, n64_response=32'hCAFE_0001.
REQ-028 SHALL test: second request cmd 8'h11 in S_EXEC -> command stays 8'h5A, STATUS bit 29=1; STATUS write 0x2000_0000 clears it.
REQ-029 SHALL test: STATUS write 0x8000_0000 -> cpu_bootstrapped=1, unchanged after later STATUS write 0x0.
REQ-030 SHALL test with CMD_WATCHDOG_EN, TIMEOUT_CYCLES=16: request, no CPU action -> after 16 cycles response=32'hFFFF_FFFF, busy=0, timeout bit=1.
REQ-031 SHALL test: reset_n asserted mid S_EXEC -> all outputs 0 asynchronously; next request accepted normally.
